// File: rtl/ctrl_rx_cmd_decoder.sv
// Receive-side command decoder: turns framed UART bytes into regfile/ALU strobes.
// Latency: one cycle; every action is registered on the edge that samples its byte.
// Backpressure: none; bytes arriving while an ALU operation is in flight are dropped.
module ctrl_rx_cmd_decoder #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 4,
  parameter int                FUN_W       = 4,
  parameter logic [DATA_W-1:0] CMD_WR      = 8'hAA,
  parameter logic [DATA_W-1:0] CMD_RD      = 8'hBB,
  parameter logic [DATA_W-1:0] CMD_ALU_OP  = 8'hCC,
  parameter logic [DATA_W-1:0] CMD_ALU_NOP = 8'hDD
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] RX_P_DATA,
  input  logic              RX_D_VLD,
  input  logic              ALU_OUT_VLD,
  output logic [ADDR_W-1:0] Address,
  output logic              WrEn,
  output logic              RdEn,
  output logic [DATA_W-1:0] WrData,
  output logic              ALU_EN,
  output logic [FUN_W-1:0]  ALU_FUN,
  output logic              CLK_EN
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WR_ADDR   = 3'd1;
  localparam logic [2:0] WR_DATA   = 3'd2;
  localparam logic [2:0] RD_ADDR   = 3'd3;
  localparam logic [2:0] OP_A      = 3'd4;
  localparam logic [2:0] OP_B      = 3'd5;
  localparam logic [2:0] ALU_FUN_S = 3'd6;
  localparam logic [2:0] ALU_WAIT  = 3'd7;

  logic [2:0]        state;
  logic [ADDR_W-1:0] wr_addr;

  // Frame parser: strobes default low each cycle, address/data/function hold between strobes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      wr_addr <= '0;
      Address <= '0;
      WrEn    <= 1'b0;
      RdEn    <= 1'b0;
      WrData  <= '0;
      ALU_EN  <= 1'b0;
      ALU_FUN <= '0;
      CLK_EN  <= 1'b0;
    end else begin
      WrEn   <= 1'b0;
      RdEn   <= 1'b0;
      ALU_EN <= 1'b0;
      case (state)
        IDLE: begin
          if (RX_D_VLD) begin
            case (RX_P_DATA)
              CMD_WR:      state <= WR_ADDR;
              CMD_RD:      state <= RD_ADDR;
              CMD_ALU_OP:  state <= OP_A;
              CMD_ALU_NOP: state <= ALU_FUN_S;
              default:     state <= IDLE;
            endcase
          end
        end
        WR_ADDR: begin
          if (RX_D_VLD) begin
            wr_addr <= RX_P_DATA[ADDR_W-1:0];
            state   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (RX_D_VLD) begin
            Address <= wr_addr;
            WrData  <= RX_P_DATA;
            WrEn    <= 1'b1;
            state   <= IDLE;
          end
        end
        RD_ADDR: begin
          if (RX_D_VLD) begin
            Address <= RX_P_DATA[ADDR_W-1:0];
            RdEn    <= 1'b1;
            state   <= IDLE;
          end
        end
        // Operands land in fixed registers 0 and 1 where the ALU reads them.
        OP_A: begin
          if (RX_D_VLD) begin
            Address <= ADDR_W'(0);
            WrData  <= RX_P_DATA;
            WrEn    <= 1'b1;
            state   <= OP_B;
          end
        end
        OP_B: begin
          if (RX_D_VLD) begin
            Address <= ADDR_W'(1);
            WrData  <= RX_P_DATA;
            WrEn    <= 1'b1;
            state   <= ALU_FUN_S;
          end
        end
        // Clock gate opens together with the start strobe so the ALU sees its first edge.
        ALU_FUN_S: begin
          if (RX_D_VLD) begin
            ALU_FUN <= RX_P_DATA[FUN_W-1:0];
            ALU_EN  <= 1'b1;
            CLK_EN  <= 1'b1;
            state   <= ALU_WAIT;
          end
        end
        // Incoming bytes are not decoded here; only the ALU result ends the operation.
        ALU_WAIT: begin
          if (ALU_OUT_VLD) begin
            CLK_EN <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          CLK_EN <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ctrl_rx_cmd_decoder.md
Name: ctrl_rx_cmd_decoder

Overview:
- Receive-side system controller; mirror of the TX controller. Sits between the UART RX deserializer and the register file / ALU.
- Parses framed command bytes from the UART into register-file write/read strobes and ALU operation requests.
- Gates the ALU clock on only while an ALU operation is in flight.

Parameters:
DATA_W, 8, width of UART bytes, register-file data and operands
ADDR_W, 4, register-file address width; taken from byte[ADDR_W-1:0]
FUN_W, 4, ALU function code width; taken from byte[FUN_W-1:0]
CMD_WR, 8'hAA, register-write command code
CMD_RD, 8'hBB, register-read command code
CMD_ALU_OP, 8'hCC, ALU-with-operands command code
CMD_ALU_NOP, 8'hDD, ALU-without-operands command code

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-low reset
RX_P_DATA  in  DATA_W  received byte; valid only when RX_D_VLD=1
RX_D_VLD  in  1  one-cycle strobe per received byte
ALU_OUT_VLD  in  1  ALU result valid; ends an ALU operation
Address  out  ADDR_W  register-file address
WrEn  out  1  register-file write strobe, one cycle
RdEn  out  1  register-file read strobe, one cycle
WrData  out  DATA_W  register-file write data
ALU_EN  out  1  ALU start strobe, one cycle
ALU_FUN  out  FUN_W  ALU function select
CLK_EN  out  1  ALU clock-gate enable

Behaviour:
- Clock and reset: CLK is the system clock. RST is asynchronous and active-low.
- Register timing: all outputs are registers. An action triggered by a byte sampled on edge N is visible after edge N and lasts one cycle for strobes.
- Reset values: state=IDLE; Address=0, WrEn=0, RdEn=0, WrData=0, ALU_EN=0, ALU_FUN=0, CLK_EN=0. Reset mid-frame discards the partial frame with no strobes; the next byte is treated as a command.
- Hold rule: Address, WrData and ALU_FUN hold their last values between strobes. WrEn, RdEn and ALU_EN default to 0 every cycle.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN_S, ALU_WAIT.
- IDLE: on RX_D_VLD, decode the byte:
  - CMD_WR -> WR_ADDR
  - CMD_RD -> RD_ADDR
  - CMD_ALU_OP -> OP_A
  - CMD_ALU_NOP -> ALU_FUN_S
  - any other byte is ignored; stay in IDLE with no strobe.
- WR_ADDR: on RX_D_VLD, latch byte[ADDR_W-1:0] internally -> WR_DATA. No strobe.
- WR_DATA: on RX_D_VLD, Address=latched address, WrData=byte, WrEn=1 -> IDLE.
- RD_ADDR: on RX_D_VLD, Address=byte[ADDR_W-1:0], RdEn=1 -> IDLE.
- OP_A: on RX_D_VLD, Address=0, WrData=byte, WrEn=1 -> OP_B.
- OP_B: on RX_D_VLD, Address=1, WrData=byte, WrEn=1 -> ALU_FUN_S.
- ALU_FUN_S: on RX_D_VLD, ALU_FUN=byte[FUN_W-1:0], ALU_EN=1, CLK_EN=1 (set on the same edge) -> ALU_WAIT.
- ALU_WAIT: CLK_EN held 1, ALU_EN=0.
  - When ALU_OUT_VLD=1 -> IDLE; CLK_EN=0 from the following edge.
  - RX_D_VLD while in ALU_WAIT is dropped; it is not decoded as a command.
- Non-IDLE states without RX_D_VLD: hold state indefinitely; no timeout.
- Ordering: one byte per strobe. Back-to-back RX_D_VLD on consecutive cycles are each consumed in order.
- Strobe exclusivity: WrEn and RdEn are never high in the same cycle.
- Unused encodings: an illegal or unused state goes to IDLE with all strobes 0.

Test Plan:
- Register write: bytes AA, 05, 3C with gaps -> one cycle of WrEn=1, Address=5, WrData=3C after the third byte; no other strobes.
- Register read: bytes BB, 0A -> one cycle of RdEn=1, Address=A; WrEn stays 0.
- ALU with operands: bytes CC, 12, 34, 02 -> WrEn at Address=0/WrData=12, then WrEn at Address=1/WrData=34, then ALU_EN pulse with ALU_FUN=2 and CLK_EN=1. Raise ALU_OUT_VLD 3 cycles later -> CLK_EN=0 one cycle after, state IDLE.
- ALU without operands: DD, 07 -> ALU_EN pulse with ALU_FUN=7, no WrEn. A byte AA arriving during ALU_WAIT is ignored, so a following 05, 3C does not write.
- Unknown command and back-to-back bytes: byte 55 -> no strobe. Bytes AA, 03, FF on consecutive cycles -> WrEn with Address=3, WrData=FF.
- Reset mid-frame: AA, 05, assert RST, release, then BB, 02 -> no WrEn ever; RdEn with Address=2. All outputs are 0 during reset.
